flick_conditioner: RTL
======================

Name: flick_conditioner

Overview:
- Conditions the raw, asynchronous flick push-button before it reaches the bound-flasher control block.
- Synchronises the input, then debounces it with a qualification FSM.
- Outputs a clean flick level, consumed by the control block for start and kickback, plus one-cycle rise and fall pulses.
- Sits directly upstream of the control block, in the clk domain.

Parameters:
SYNC_STAGES, 2, synchroniser flops on flick_raw; legal values >=2.
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples needed to accept a level change; legal values >=1.
Derived localparam DB_CNT_W = $clog2(DEBOUNCE_CYCLES+1).

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
flick_raw  input  1  asynchronous button level, may chatter
enable  input  1  conditioner enable; 0 forces output inactive
flick  output  1  debounced registered level to control block
flick_rise  output  1  one-cycle pulse when flick goes 0->1
flick_fall  output  1  one-cycle pulse when flick goes 1->0
glitch_cnt  output  8  rejected-glitch count (present only with FLICK_GLITCH_CNT_EN)

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - sync chain = 0, FSM = IDLE_LOW, debounce count = 0.
  - flick = 0, flick_rise = 0, flick_fall = 0, glitch_cnt = 0.
  - Reset overrides enable and all other inputs.
- Synchroniser: s = flick_raw delayed through SYNC_STAGES flops. It runs whenever rst_n=1, regardless of enable.
- FSM states:
  - IDLE_LOW (flick=0)
  - QUAL_HIGH (flick=0)
  - STABLE_HIGH (flick=1)
  - QUAL_LOW (flick=1)
- Transitions:
  - IDLE_LOW: s=1 -> QUAL_HIGH, count starts.
  - QUAL_HIGH:
    - s=0 -> IDLE_LOW, count cleared, glitch recorded.
    - s=1 for DEBOUNCE_CYCLES consecutive samples -> STABLE_HIGH; flick=1 and flick_rise=1 on that edge.
  - STABLE_HIGH: s=0 -> QUAL_LOW.
  - QUAL_LOW:
    - s=1 -> STABLE_HIGH, glitch recorded.
    - s=0 for DEBOUNCE_CYCLES consecutive samples -> IDLE_LOW; flick=0 and flick_fall=1 on that edge.
- Latency: if flick_raw is first sampled at a new value on edge T0 and then held, flick takes the new value exactly on edge T0+SYNC_STAGES+DEBOUNCE_CYCLES. The same holds for both polarities.
- Pulses:
  - Registered, high for exactly one cycle, coincident with the flick change.
  - flick_rise and flick_fall are never high together.
- Glitch rejection: any return of s to the current flick value during qualification aborts the qualification and restarts the count from 0 on the next differing sample. flick never changes on a glitch.
- DEBOUNCE_CYCLES=1: the first differing sample qualifies, so no glitch is possible.
- Count width: the counter saturates at DEBOUNCE_CYCLES and never wraps.
- enable=0:
  - Next edge: FSM -> IDLE_LOW, count cleared, flick=0.
  - No flick_fall pulse, even if flick was 1; no flick_rise.
  - Sync chain keeps sampling.
- Re-enable with s already 1: normal QUAL_HIGH path. flick rises DEBOUNCE_CYCLES edges after enable=1 is first sampled.
- Reset mid-qualification: count is discarded; the FSM returns to IDLE_LOW the same edge.

Optional Feature:
- Macro FLICK_GLITCH_CNT_EN.
- Defined:
  - The glitch_cnt port exists as an 8-bit register.
  - It increments by 1 on each aborted qualification (QUAL_HIGH->IDLE_LOW or QUAL_LOW->STABLE_HIGH) and saturates at 255.
  - Cleared only by reset; enable=0 does not clear it.
  - An abort caused by enable=0 is not counted.
- Undefined: the port and register are absent, and all other behaviour is identical.

Test Plan:
1. Reset: rst_n=0 for 3 cycles with flick_raw=1 -> flick, flick_rise, flick_fall and glitch_cnt are 0 throughout. After release, flick rises exactly 18 edges (defaults) after the first post-reset sample of 1.
2. Clean press (defaults): flick_raw 0->1 first sampled at edge 10, held -> flick=1 from edge 28; flick_rise=1 only at edge 28.
3. Glitch: 5-cycle high pulse on flick_raw -> flick stays 0, no pulses; glitch_cnt=1 with the macro defined.
4. Release: from stable high, flick_raw 1->0 sampled at edge 100 -> flick=0 at edge 118, flick_fall=1 only at edge 118.
5. Enable drop: flick=1, enable 1->0 sampled at edge 50 -> flick=0 from edge 50, no flick_fall. enable=1 again at edge 60 with flick_raw held 1 -> flick_rise at edge 76.
6. Chatter: flick_raw toggles every 3 cycles for 40 cycles, then held 1 -> exactly one flick_rise, no flick_fall. glitch_cnt equals the number of aborted qualifications, checked against the model.

Source files
------------

// File: rtl/flick_conditioner.sv
// Flick push-button conditioner: synchroniser, debounce qualification FSM, edge pulses.
// Optional rejected-glitch counter enabled by defining FLICK_GLITCH_CNT_EN.
module flick_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flick_raw,
    input  logic       enable,
    output logic       flick,
    output logic       flick_rise,
    output logic       flick_fall
`ifdef FLICK_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam int unsigned DB_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_CNT_W-1:0] CNT_ONE = DB_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        QUAL_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        QUAL_LOW    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [DB_CNT_W-1:0]    cnt_q, cnt_d;
    logic                   flick_d, rise_d, fall_d;
    logic                   qualified;

    // Synchroniser runs regardless of enable
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], flick_raw};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE_LOW;
            cnt_q      <= '0;
            flick      <= 1'b0;
            flick_rise <= 1'b0;
            flick_fall <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flick      <= flick_d;
            flick_rise <= rise_d;
            flick_fall <= fall_d;
        end
    end

    // A full count means DEBOUNCE_CYCLES consecutive differing samples were already seen
    assign qualified = (cnt_q >= CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE_LOW: begin
                    if (s) begin
                        state_d = QUAL_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                QUAL_HIGH: begin
                    if (qualified) begin
                        state_d = STABLE_HIGH;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else if (!s) begin
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state_d = QUAL_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
                QUAL_LOW: begin
                    if (qualified) begin
                        state_d = IDLE_LOW;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else if (s) begin
                        state_d = STABLE_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
        flick_d = (state_d == STABLE_HIGH) || (state_d == QUAL_LOW);
    end

`ifdef FLICK_GLITCH_CNT_EN
    logic glitch_c;

    // Aborted qualification; disable-forced aborts are not glitches
    always_comb begin
        glitch_c = 1'b0;
        if (enable && !qualified) begin
            glitch_c = ((state_q == QUAL_HIGH) && !s) || ((state_q == QUAL_LOW) && s);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                          glitch_cnt <= 8'd0;
        else if (glitch_c && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
    end
`endif

endmodule
